// File: rtl/div_sequencer.sv
// Sequencer between the EXE stage and the shared iterative divider: launches one
// divide at a time, stalls EXE until the result returns, and keeps a 1-entry result cache.
module div_sequencer #(
    parameter int unsigned TIMEOUT = 40
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        req_valid_i,
    input  logic [31:0] req_op1_i,
    input  logic [31:0] req_op2_i,
    input  logic [1:0]  req_cmd_i,
    input  logic        flush_i,
    output logic        stall_o,
    output logic        rsp_valid_o,
    output logic [31:0] rsp_data_o,
    output logic        err_o,
    output logic        div_start_o,
    output logic [31:0] div_op1_o,
    output logic [31:0] div_op2_o,
    output logic [1:0]  div_cmd_o,
    input  logic        div_done_i,
    input  logic [31:0] div_res_i
);

    localparam int unsigned CW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(TIMEOUT);

    typedef enum logic [2:0] {
        IDLE,
        LAUNCH,
        WAIT,
        RESP,
        DRAIN
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [31:0]   op1_q, op1_d;
    logic [31:0]   op2_q, op2_d;
    logic [1:0]    cmd_q, cmd_d;
    logic [31:0]   rsp_data_q, rsp_data_d;
    logic          err_q, err_d;
    logic          cache_vld_q, cache_vld_d;
    logic [31:0]   cache_op1_q, cache_op1_d;
    logic [31:0]   cache_op2_q, cache_op2_d;
    logic [1:0]    cache_cmd_q, cache_cmd_d;
    logic [31:0]   cache_data_q, cache_data_d;

    logic          cache_hit;
    logic [CW-1:0] cnt_inc;
    logic          timeout;

    assign cache_hit = cache_vld_q &&
                       ({cache_op1_q, cache_op2_q, cache_cmd_q} == {req_op1_i, req_op2_i, req_cmd_i});
    assign cnt_inc   = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;
    assign timeout   = (cnt_inc == CNT_MAX);

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        op1_d        = op1_q;
        op2_d        = op2_q;
        cmd_d        = cmd_q;
        rsp_data_d   = rsp_data_q;
        err_d        = err_q;
        cache_vld_d  = cache_vld_q;
        cache_op1_d  = cache_op1_q;
        cache_op2_d  = cache_op2_q;
        cache_cmd_d  = cache_cmd_q;
        cache_data_d = cache_data_q;
        stall_o      = 1'b0;
        rsp_valid_o  = 1'b0;
        div_start_o  = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (req_valid_i && !flush_i) begin
                    stall_o = 1'b1;
                    op1_d   = req_op1_i;
                    op2_d   = req_op2_i;
                    cmd_d   = req_cmd_i;
                    if (cache_hit) begin
                        rsp_data_d = cache_data_q;
                        state_d    = RESP;
                    end else begin
                        state_d = LAUNCH;
                    end
                end
            end
            LAUNCH: begin
                // Start is issued even on flush: the divider has already taken the operands.
                div_start_o = 1'b1;
                stall_o     = !flush_i;
                cnt_d       = '0;
                state_d     = flush_i ? DRAIN : WAIT;
            end
            WAIT: begin
                stall_o = !flush_i;
                cnt_d   = cnt_inc;
                if (flush_i) begin
                    state_d = div_done_i ? IDLE : DRAIN;
                end else if (div_done_i) begin
                    rsp_data_d   = div_res_i;
                    cache_vld_d  = 1'b1;
                    cache_op1_d  = op1_q;
                    cache_op2_d  = op2_q;
                    cache_cmd_d  = cmd_q;
                    cache_data_d = div_res_i;
                    state_d      = RESP;
                end else if (timeout) begin
                    err_d       = 1'b1;
                    cache_vld_d = 1'b0;
                    rsp_data_d  = '0;
                    state_d     = RESP;
                end
            end
            RESP: begin
                rsp_valid_o = !flush_i;
                state_d     = IDLE;
            end
            DRAIN: begin
                // A killed divide is still running; hold off any new op until it lands.
                stall_o = req_valid_i;
                cnt_d   = cnt_inc;
                if (div_done_i) begin
                    state_d = IDLE;
                end else if (timeout) begin
                    err_d   = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            op1_q        <= '0;
            op2_q        <= '0;
            cmd_q        <= '0;
            rsp_data_q   <= '0;
            err_q        <= 1'b0;
            cache_vld_q  <= 1'b0;
            cache_op1_q  <= '0;
            cache_op2_q  <= '0;
            cache_cmd_q  <= '0;
            cache_data_q <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            op1_q        <= op1_d;
            op2_q        <= op2_d;
            cmd_q        <= cmd_d;
            rsp_data_q   <= rsp_data_d;
            err_q        <= err_d;
            cache_vld_q  <= cache_vld_d;
            cache_op1_q  <= cache_op1_d;
            cache_op2_q  <= cache_op2_d;
            cache_cmd_q  <= cache_cmd_d;
            cache_data_q <= cache_data_d;
        end
    end

    assign rsp_data_o = rsp_data_q;
    assign err_o      = err_q;
    assign div_op1_o  = op1_q;
    assign div_op2_o  = op2_q;
    assign div_cmd_o  = cmd_q;

endmodule

// File: tb/tb_div_sequencer.sv
// Scoreboard bench for div_sequencer: a behavioural divider + cache model predicts each
// response; a monitor pops predictions whenever rsp_valid_o fires.
module tb_div_sequencer;

    localparam int NONE = 1000;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        req_valid_i;
    logic [31:0] req_op1_i;
    logic [31:0] req_op2_i;
    logic [1:0]  req_cmd_i;
    logic        flush_i;
    logic        stall_o;
    logic        rsp_valid_o;
    logic [31:0] rsp_data_o;
    logic        err_o;
    logic        div_start_o;
    logic [31:0] div_op1_o;
    logic [31:0] div_op2_o;
    logic [1:0]  div_cmd_o;
    logic        div_done_i;
    logic [31:0] div_res_i;

    div_sequencer #(.TIMEOUT(40)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .req_valid_i (req_valid_i),
        .req_op1_i   (req_op1_i),
        .req_op2_i   (req_op2_i),
        .req_cmd_i   (req_cmd_i),
        .flush_i     (flush_i),
        .stall_o     (stall_o),
        .rsp_valid_o (rsp_valid_o),
        .rsp_data_o  (rsp_data_o),
        .err_o       (err_o),
        .div_start_o (div_start_o),
        .div_op1_o   (div_op1_o),
        .div_op2_o   (div_op2_o),
        .div_cmd_o   (div_cmd_o),
        .div_done_i  (div_done_i),
        .div_res_i   (div_res_i)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc = cyc + 1;

    int n_chk = 0;
    int n_pass = 0;

    typedef struct {
        logic [31:0] data;
        int          cyc;
        bit          chk_cyc;
    } exp_t;
    exp_t exp_q[$];

    // reference state: cache contents and counters
    bit          m_valid = 1'b0;
    logic [31:0] m_a, m_b, m_data;
    logic [1:0]  m_c;
    logic        exp_err = 1'b0;
    int          exp_starts = 0;
    int          start_cnt = 0;

    // divider model controls
    int          dv_lat = 1;
    bit          dv_busy = 1'b0;
    int          dv_rem = 0;
    logic [31:0] dv_res = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    endtask

    // RISC-V M-extension divide semantics
    function automatic logic [31:0] ref_div(input logic [31:0] a, input logic [31:0] b,
                                            input logic [1:0] c);
        longint sa, sb, r;
        sa = $signed(a);
        sb = $signed(b);
        case (c)
            2'b00: ref_div = (b == 0) ? a : a % b;
            2'b10: ref_div = (b == 0) ? 32'hFFFF_FFFF : a / b;
            2'b01: begin
                if (b == 0) ref_div = 32'hFFFF_FFFF;
                else begin r = sa / sb; ref_div = r[31:0]; end
            end
            default: begin
                if (b == 0) ref_div = a;
                else begin r = sa % sb; ref_div = r[31:0]; end
            end
        endcase
    endfunction

    // behavioural divider: done arrives dv_lat cycles after the start pulse (never if <= 0)
    initial begin
        div_done_i = 1'b0;
        div_res_i  = '0;
        forever begin
            @(negedge clk);
            div_done_i = 1'b0;
            if (!reset_n) dv_busy = 1'b0;
            if (dv_busy) begin
                dv_rem--;
                if (dv_rem == 0) begin
                    div_done_i = 1'b1;
                    div_res_i  = dv_res;
                    dv_busy    = 1'b0;
                end
            end
            if (reset_n && div_start_o) begin
                start_cnt++;
                if (dv_lat > 0) begin
                    dv_busy = 1'b1;
                    dv_rem  = dv_lat;
                    dv_res  = ref_div(div_op1_o, div_op2_o, div_cmd_o);
                end
            end
        end
    end

    // monitor
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (reset_n && rsp_valid_o) begin
                if (exp_q.size() == 0) begin
                    n_chk++;
                    $display("FAIL rsp_unexpected: got rsp_valid_o=1 data 0x%08h at cycle %0d, expected no response",
                             rsp_data_o, cyc);
                end else begin
                    e = exp_q.pop_front();
                    check("rsp_data", rsp_data_o, e.data);
                    if (e.chk_cyc) check("rsp_cycle", cyc, e.cyc);
                end
            end
        end
    end

    // Present one request at the current cycle T and hold it until EXE may advance
    // (a cycle with stall_o=0). f = offset from T of a single flush cycle.
    task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic [1:0] c,
                         input int n, input int f, input bit chk);
        int t0, er, ret;
        bit hit, retired;
        logic [31:0] res;
        exp_t e;
        hit = m_valid && (m_a == a) && (m_b == b) && (m_c == c);
        res = ref_div(a, b, c);
        t0  = cyc;
        if (f == 0) er = 0;
        else if (hit) er = 1;
        else if (n <= 0) er = (f < 42) ? f : 42;
        else er = (f < n + 2) ? f : n + 2;

        if (f != 0) begin
            if (hit) begin
                if (f != 1) begin e.data = m_data; e.cyc = t0 + 1; e.chk_cyc = chk; exp_q.push_back(e); end
            end else begin
                exp_starts++;
                if (n <= 0) begin
                    if (f >= 42) begin
                        m_valid = 1'b0;
                        exp_err = 1'b1;
                        if (f > 42) begin e.data = '0; e.cyc = t0 + 42; e.chk_cyc = chk; exp_q.push_back(e); end
                    end
                end else if (f > n + 1) begin
                    m_valid = 1'b1; m_a = a; m_b = b; m_c = c; m_data = res;
                    if (f > n + 2) begin e.data = res; e.cyc = t0 + n + 2; e.chk_cyc = chk; exp_q.push_back(e); end
                end
            end
        end

        if (!hit && f != 0) dv_lat = n;
        req_valid_i = 1'b1;
        req_op1_i   = a;
        req_op2_i   = b;
        req_cmd_i   = c;
        retired     = 1'b0;
        ret         = 0;
        for (int o = 0; o < 200 && !retired; o++) begin
            flush_i = (o == f);
            @(negedge clk);
            retired = !stall_o;
            ret     = o;
            @(posedge clk);
            #1;
        end
        req_valid_i = 1'b0;
        flush_i     = 1'b0;
        if (!retired) begin
            n_chk++;
            $display("FAIL retire_timeout: stall_o still 1 after 200 cycles, expected release");
        end else if (chk) begin
            check("retire_cycle", ret, er);
        end
        check("err", err_o, exp_err);
        check("start_count", start_cnt, exp_starts);
    endtask

    task automatic wait_idle();
        int k;
        k = 0;
        while (dv_busy && k < 100) begin
            @(posedge clk);
            #1;
            k++;
        end
        if (dv_busy) begin
            n_chk++;
            $display("FAIL drain_timeout: divider still busy after 100 cycles, expected idle");
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] pool [4];
        logic [31:0] a, b;
        logic [1:0]  c;
        int          n, f;
        pool[0] = 32'd100; pool[1] = 32'd7; pool[2] = 32'h8000_0000; pool[3] = 32'hFFFF_FFFF;

        reset_n = 1'b0; req_valid_i = 1'b0; req_op1_i = '0; req_op2_i = '0;
        req_cmd_i = '0; flush_i = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_ctl", {26'd0, stall_o, rsp_valid_o, err_o, div_start_o, div_cmd_o}, '0);
        check("rst_rsp_data", rsp_data_o, '0);
        check("rst_op1", div_op1_o, '0);
        check("rst_op2", div_op2_o, '0);
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;

        // 1: miss, done 33 cycles after start
        issue(32'd100, 32'd7, 2'b10, 33, NONE, 1);
        // 2: identical request hits
        issue(32'd100, 32'd7, 2'b10, 33, NONE, 1);
        // 3: cmd differs -> miss
        issue(32'd100, 32'd7, 2'b00, 10, NONE, 1);
        // 4: flush 5 cycles into WAIT, then a new op presented while draining
        issue(32'hFFFF_FFF6, 32'd3, 2'b01, 20, 7, 1);
        issue(32'd9, 32'd3, 2'b10, 4, NONE, 0);
        issue(32'd9, 32'd3, 2'b10, 4, NONE, 1);
        // flush leaves the cache intact: drain, then REMU 100/7 still... cache now holds DIVU 9/3
        issue(32'd50, 32'd6, 2'b11, 12, 4, 1);
        wait_idle();
        issue(32'd9, 32'd3, 2'b10, 4, NONE, 1);
        // 5: flush together with done
        issue(32'd77, 32'd5, 2'b10, 6, 7, 1);
        issue(32'd77, 32'd5, 2'b10, 6, NONE, 1);
        // flush in RESP still fills the cache; flush in IDLE ignores the request
        issue(32'd81, 32'd9, 2'b01, 3, 5, 1);
        issue(32'd81, 32'd9, 2'b01, 3, NONE, 1);
        issue(32'd64, 32'd4, 2'b00, 3, 0, 1);

        for (int i = 0; i < 60; i++) begin
            a = ($urandom_range(0, 3) == 0) ? $urandom : pool[$urandom_range(0, 3)];
            b = ($urandom_range(0, 5) == 0) ? 32'd0 : pool[$urandom_range(0, 3)];
            c = 2'($urandom_range(0, 3));
            n = $urandom_range(1, 35);
            f = ($urandom_range(0, 9) < 3) ? $urandom_range(0, n + 3) : NONE;
            issue(a, b, c, n, f, 1);
            wait_idle();
        end

        // 6: divider never answers -> timeout with zero data
        issue(32'd50, 32'd5, 2'b10, -1, NONE, 1);
        dv_lat      = -1;
        req_valid_i = 1'b1;
        req_op1_i   = 32'd51;
        req_op2_i   = 32'd5;
        req_cmd_i   = 2'b10;
        exp_starts++;
        repeat (6) @(posedge clk);
        #3;
        check("start_count", start_cnt, exp_starts);
        req_valid_i = 1'b0;
        reset_n     = 1'b0;
        #1;
        check("async_rst_ctl", {26'd0, stall_o, rsp_valid_o, err_o, div_start_o, div_cmd_o}, '0);
        check("async_rst_rsp_data", rsp_data_o, '0);
        check("async_rst_op1", div_op1_o, '0);
        check("async_rst_op2", div_op2_o, '0);
        m_valid = 1'b0;
        exp_err = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        // reset invalidated the cache: this earlier-cached request must relaunch
        issue(32'd100, 32'd7, 2'b10, 5, NONE, 1);

        repeat (3) @(posedge clk);
        #1;
        check("exp_queue_empty", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
